// File: rtl/lca_seq.sv
// Multi-byte add/subtract sequencer that time-shares one external 8-bit adder,
// issuing LSB byte first and rippling carry through a register between bytes.
module lca_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*WORDS-1:0]   op_a,
    input  logic [8*WORDS-1:0]   op_b,
    input  logic                 op_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORDS-1:0]   result,
    output logic                 carry_out,
    output logic                 overflow,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    output logic                 add_cin,
    input  logic [7:0]           add_sum,
    input  logic                 add_cout
);

    localparam int W  = 8 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic            sub_q, sub_d;
    logic            carry_q, carry_d;
    logic            carry_out_q, carry_out_d;
    logic            overflow_q, overflow_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [7:0]      a_bytes [WORDS];
    logic [7:0]      b_bytes [WORDS];
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic            last_byte;
    logic            running;

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_bytes
        assign a_bytes[gi] = a_q[8*gi +: 8];
        assign b_bytes[gi] = b_q[8*gi +: 8];
    end

    // B byte is inverted here so the adder performs A + ~B + carry for subtract
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) begin
                a_byte = a_bytes[i];
                b_byte = b_bytes[i] ^ {8{sub_q}};
            end
        end
    end

    assign running   = (state_q == RUN);
    assign last_byte = (idx_q == IW'(WORDS - 1));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign add_a     = running ? a_byte  : 8'h00;
    assign add_b     = running ? b_byte  : 8'h00;
    assign add_cin   = running ? carry_q : 1'b0;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = op_sub;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IW'(i)) begin
                        result_d[8*i +: 8] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (last_byte) begin
                    // Index holds on the last byte; it is cleared on the next accept
                    carry_out_d = add_cout;
                    overflow_d  = (a_byte[7] == b_byte[7]) && (add_sum[7] != a_byte[7]);
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_lca_seq.sv
// Scoreboard bench for lca_seq: a 4-byte and a 1-byte instance, each driving
// its own behavioural 8-bit adder.
module tb_lca_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WORDS=4 instance signals
    logic        in_valid4, in_ready4, op_sub4, out_valid4, out_ready4;
    logic [31:0] op_a4, op_b4, result4;
    logic        carry_out4, overflow4;
    logic [7:0]  add_a4, add_b4, add_sum4;
    logic        add_cin4, add_cout4;

    // WORDS=1 instance signals
    logic        in_valid1, in_ready1, op_sub1, out_valid1, out_ready1;
    logic [7:0]  op_a1, op_b1, result1;
    logic        carry_out1, overflow1;
    logic [7:0]  add_a1, add_b1, add_sum1;
    logic        add_cin1, add_cout1;

    assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {8'h00, add_cin4};
    assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {8'h00, add_cin1};

    lca_seq #(.WORDS(4)) u4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .op_a(op_a4), .op_b(op_b4), .op_sub(op_sub4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .result(result4), .carry_out(carry_out4), .overflow(overflow4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4)
    );

    lca_seq #(.WORDS(1)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .op_a(op_a1), .op_b(op_b1), .op_sub(op_sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .carry_out(carry_out1), .overflow(overflow1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        o;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push4(input logic [31:0] r, input logic c, input logic o);
        exp_t e;
        e.res = r; e.c = c; e.o = o;
        q4.push_back(e);
    endtask

    task automatic push1(input logic [7:0] r, input logic c, input logic o);
        exp_t e;
        e.res = {24'h0, r}; e.c = c; e.o = o;
        q1.push_back(e);
    endtask

    // Returns #1 after the accept edge; operands are then scrambled to show they are ignored
    task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        in_valid4 = 1'b1; op_a4 = a; op_b4 = b; op_sub4 = s;
        n = 0;
        while (!in_ready4 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("u4_accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        in_valid4 = 1'b0; op_a4 = 32'hDEADBEEF; op_b4 = 32'h0BADF00D; op_sub4 = ~s;
    endtask

    task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n;
        in_valid1 = 1'b1; op_a1 = a; op_b1 = b; op_sub1 = s;
        n = 0;
        while (!in_ready1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("u1_accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0; op_a1 = 8'h5A; op_b1 = 8'hA5; op_sub1 = ~s;
    endtask

    task automatic wait_valid4();
        int n;
        n = 0;
        while (!out_valid4 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("u4_out_valid_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic wait_valid1();
        int n;
        n = 0;
        while (!out_valid1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("u1_out_valid_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] r, input logic c, input logic o);
        push4(r, c, o);
        send4(a, b, s);
        wait_valid4();
        @(posedge clk); #1;
    endtask

    // Handshake completes on the following edge when out_valid & out_ready are seen here
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid4 && out_ready4) begin
                    if (q4.size() == 0) begin
                        total++; bad++;
                        $display("FAIL u4_unexpected_output: got result=%h expected no output", result4);
                    end else begin
                        e = q4.pop_front();
                        $display("u4 txn: result=%h carry=%b ovf=%b (exp %h %b %b)",
                                 result4, carry_out4, overflow4, e.res, e.c, e.o);
                        check("u4_result", result4, e.res);
                        check("u4_carry_out", 32'(carry_out4), 32'(e.c));
                        check("u4_overflow", 32'(overflow4), 32'(e.o));
                    end
                end
                if (out_valid1 && out_ready1) begin
                    if (q1.size() == 0) begin
                        total++; bad++;
                        $display("FAIL u1_unexpected_output: got result=%h expected no output", result1);
                    end else begin
                        e = q1.pop_front();
                        $display("u1 txn: result=%h carry=%b ovf=%b (exp %h %b %b)",
                                 result1, carry_out1, overflow1, e.res[7:0], e.c, e.o);
                        check("u1_result", {24'h0, result1}, e.res);
                        check("u1_carry_out", 32'(carry_out1), 32'(e.c));
                        check("u1_overflow", 32'(overflow1), 32'(e.o));
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid4 = 1'b0; op_a4 = '0; op_b4 = '0; op_sub4 = 1'b0; out_ready4 = 1'b1;
        in_valid1 = 1'b0; op_a1 = '0; op_b1 = '0; op_sub1 = 1'b0; out_ready1 = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready4), 32'd1);
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check("rst_result", result4, 32'd0);
        check("rst_flags", {30'd0, carry_out4, overflow4}, 32'd0);
        check("rst_add_bus", {15'd0, add_a4, add_b4, add_cin4}, 32'd0);
        check("rst_u1_in_ready", 32'(in_ready1), 32'd1);
        check("rst_u1_out_valid", 32'(out_valid1), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 0xFF + 1: carry ripples from byte 0 into byte 1, result after 4 edges
        push4(32'h0000_0100, 1'b0, 1'b0);
        send4(32'h0000_00FF, 32'h0000_0001, 1'b0);
        check("t1_b0_add_a", 32'(add_a4), 32'h0000_00FF);
        check("t1_b0_add_b", 32'(add_b4), 32'h0000_0001);
        check("t1_b0_add_cin", 32'(add_cin4), 32'd0);
        check("t1_b0_in_ready", 32'(in_ready4), 32'd0);
        @(posedge clk); #1;
        check("t1_b1_add_a", 32'(add_a4), 32'd0);
        check("t1_b1_add_b", 32'(add_b4), 32'd0);
        check("t1_b1_add_cin", 32'(add_cin4), 32'd1);
        @(posedge clk); #1;
        check("t1_lat_edge2", 32'(out_valid4), 32'd0);
        @(posedge clk); #1;
        check("t1_lat_edge3", 32'(out_valid4), 32'd0);
        @(posedge clk); #1;
        check("t1_lat_edge4", 32'(out_valid4), 32'd1);
        @(posedge clk); #1;

        run4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

        // 5 - 7: inverted B byte with carry-in 1
        push4(32'hFFFF_FFFE, 1'b0, 1'b0);
        send4(32'd5, 32'd7, 1'b1);
        check("t4_sub_add_b", 32'(add_b4), 32'h0000_00F8);
        check("t4_sub_add_cin", 32'(add_cin4), 32'd1);
        wait_valid4();
        @(posedge clk); #1;

        run4(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure: result held for 3 cycles, next request waits with in_valid held
        out_ready4 = 1'b0;
        push4(32'h2345_6789, 1'b0, 1'b0);
        send4(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_valid4();
        push4(32'h0000_0003, 1'b0, 1'b0);
        in_valid4 = 1'b1; op_a4 = 32'd1; op_b4 = 32'd2; op_sub4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp_out_valid", 32'(out_valid4), 32'd1);
            check("bp_result", result4, 32'h2345_6789);
            check("bp_flags", {30'd0, carry_out4, overflow4}, 32'd0);
            check("bp_in_ready", 32'(in_ready4), 32'd0);
            @(posedge clk); #1;
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(out_valid4), 32'd0);
        check("bp_release_in_ready", 32'(in_ready4), 32'd1);
        @(posedge clk); #1;
        check("bp_next_accepted", 32'(in_ready4), 32'd0);
        in_valid4 = 1'b0;
        wait_valid4();
        @(posedge clk); #1;

        // Reset during RUN byte 2 aborts with no output
        send4(32'h0101_0101, 32'h0202_0202, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready4), 32'd1);
        check("abort_out_valid", 32'(out_valid4), 32'd0);
        check("abort_result", result4, 32'd0);
        check("abort_add_bus", {15'd0, add_a4, add_b4, add_cin4}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("abort_no_output", 32'(out_valid4), 32'd0);
        end
        run4(32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);

        // WORDS=1: 0x80 + 0x80, single RUN cycle
        push1(8'h00, 1'b1, 1'b1);
        send1(8'h80, 8'h80, 1'b0);
        check("w1_add_a", 32'(add_a1), 32'h80);
        check("w1_lat_edge0", 32'(out_valid1), 32'd0);
        @(posedge clk); #1;
        check("w1_lat_edge1", 32'(out_valid1), 32'd1);
        @(posedge clk); #1;

        push1(8'hFE, 1'b0, 1'b0);
        send1(8'h05, 8'h07, 1'b1);
        wait_valid1();
        @(posedge clk); #1;

        repeat (4) @(posedge clk);
        #1;
        check("u4_scoreboard_empty", 32'(q4.size()), 32'd0);
        check("u1_scoreboard_empty", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
